csr_trap_unit: RTL and testbench

- Parametrised successor to the current privilege/CSR block.
- Holds a sparse, implemented-only set of M/S CSRs instead of a flat 4096-entry array.
- Checks CSR access permissions and raises illegal-instruction traps.
- Runs the mcycle/minstret counters, prioritises and delegates interrupts and exceptions, and sequences mret/sret.
- Sits beside the execute/commit stage; the pipeline consumes the redirect outputs.

---
 rtl/csr_pkg.sv | 65 ++++++
 rtl/csr_trap_unit_irq_arbiter.sv | 41 ++++
 rtl/csr_trap_unit.sv | 257 +++++++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants for the CSR/trap unit: privilege levels, CSR addresses,
// cause codes, mstatus field positions, view masks and interrupt priority.
package csr_pkg;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_SSTATUS  = 12'h100;
  localparam logic [11:0] CSR_SIE      = 12'h104;
  localparam logic [11:0] CSR_STVEC    = 12'h105;
  localparam logic [11:0] CSR_SSCRATCH = 12'h140;
  localparam logic [11:0] CSR_SEPC     = 12'h141;
  localparam logic [11:0] CSR_SCAUSE   = 12'h142;
  localparam logic [11:0] CSR_STVAL    = 12'h143;
  localparam logic [11:0] CSR_SIP      = 12'h144;
  localparam logic [11:0] CSR_SATP     = 12'h180;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MEDELEG  = 12'h302;
  localparam logic [11:0] CSR_MIDELEG  = 12'h303;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [5:0] CAUSE_ILLEGAL_INSN = 6'd2;

  localparam int MS_SIE  = 1;
  localparam int MS_MIE  = 3;
  localparam int MS_SPIE = 5;
  localparam int MS_MPIE = 7;
  localparam int MS_SPP  = 8;
  localparam int MS_MPP  = 11;

  // UIE/UPIE are deliberately absent from every mask so they always read 0.
  localparam logic [63:0] MSTATUS_WMASK   = 64'h0000_0000_000C_19AA;
  localparam logic [63:0] MSTATUS_WMASK_M = 64'h0000_0000_0000_1888;
  localparam logic [63:0] SSTATUS_MASK    = 64'h0000_0000_000C_0122;
  localparam logic [63:0] SIP_MASK        = 64'h0000_0000_0000_0222;
  localparam logic [63:0] MIE_MASK        = 64'h0000_0000_0000_0AAA;
  localparam logic [63:0] MIE_MASK_M      = 64'h0000_0000_0000_0888;

  localparam logic [25:0] MISA_EXT_BASE = 26'h0101101;  // A, I, M, U
  localparam logic [25:0] MISA_EXT_S    = 26'h0040000;

  localparam int IRQ_PRIO_N = 6;
  localparam logic [3:0] IRQ_PRIO [IRQ_PRIO_N] = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};

endpackage

// File: rtl/csr_trap_unit_irq_arbiter.sv
// Qualifies pending interrupts by enable, delegation and current mode, then
// picks the highest-priority one.
module irq_arbiter
  import csr_pkg::*;
#(
  parameter bit HAS_S = 1'b1
) (
  input  logic [11:0] i_mip,
  input  logic [11:0] i_mie,
  input  logic [11:0] i_mideleg,
  input  logic [1:0]  i_priv,
  input  logic        i_mstatus_mie,
  input  logic        i_mstatus_sie,
  output logic        o_pending,
  output logic [5:0]  o_cause
);

  logic [11:0] w_pend;
  logic        w_m_glob;
  logic        w_s_glob;
  logic [11:0] w_enabled;

  assign w_pend    = i_mip & i_mie;
  assign w_m_glob  = (i_priv != PRIV_M) || i_mstatus_mie;
  assign w_s_glob  = HAS_S && ((i_priv == PRIV_U) || ((i_priv == PRIV_S) && i_mstatus_sie));
  assign w_enabled = (w_pend & ~i_mideleg & {12{w_m_glob}})
                   | (w_pend &  i_mideleg & {12{w_s_glob}});

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    o_pending = 1'b0;
    o_cause   = '0;
    for (int i = IRQ_PRIO_N - 1; i >= 0; i--) begin
      if (w_enabled[IRQ_PRIO[i]]) begin
        o_pending = 1'b1;
        o_cause   = {2'b00, IRQ_PRIO[i]};
      end
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Sparse M/S CSR file with access checking, counters, trap entry with
// delegation/vectoring, and mret/sret sequencing.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int CNT_W   = 64,
  parameter bit HAS_S   = 1'b1,
  parameter int VEC_MAX = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_valid,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            csr_wr_en,
  input  logic [31:0]     csr_insn,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            retire,
  input  logic            exc_valid,
  input  logic [5:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [2:0]      irq_ext,
  input  logic            irq_take,
  input  logic [XLEN-1:0] irq_pc,
  input  logic            xret_valid,
  input  logic [1:0]      xret_priv,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            irq_pending,
  output logic [1:0]      priv_mode,
  output logic [XLEN-1:0] satp,
  output logic            satp_write
);

  localparam logic [XLEN-1:0] L_MISA =
    {2'b10, {(XLEN-28){1'b0}}, MISA_EXT_BASE | (HAS_S ? MISA_EXT_S : 26'h0)};
  localparam logic [XLEN-1:0] L_MSTATUS_W = HAS_S ? XLEN'(MSTATUS_WMASK) : XLEN'(MSTATUS_WMASK_M);
  localparam logic [XLEN-1:0] L_SSTATUS   = XLEN'(SSTATUS_MASK);
  localparam logic [XLEN-1:0] L_SIP       = XLEN'(SIP_MASK);
  localparam logic [XLEN-1:0] L_MIE_W     = HAS_S ? XLEN'(MIE_MASK) : XLEN'(MIE_MASK_M);
  localparam logic [XLEN-1:0] L_MIP_SW_W  = HAS_S ? XLEN'(SIP_MASK) : '0;

  logic [1:0]      r_priv;
  logic [XLEN-1:0] r_mstatus, r_medeleg, r_mideleg, r_mie, r_mip_sw;
  logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [XLEN-1:0] r_stvec, r_sscratch, r_sepc, r_scause, r_stval, r_satp;
  logic [CNT_W-1:0] r_mcycle, r_minstret;

  logic [XLEN-1:0] w_mip, w_rd_raw, w_wval;
  logic            w_impl, w_access, w_csr_illegal, w_xret_bad, w_xret_ok;
  logic            w_irq_pend, w_take_irq, w_trap, w_csr_we;
  logic [5:0]      w_irq_cause;
  logic            w_t_irq, w_to_s, w_vectored;
  logic [5:0]      w_t_cause;
  logic [XLEN-1:0] w_t_epc, w_t_tval, w_deleg_vec, w_tvec, w_handler;
  logic [XLEN-1:0] w_ms_trap, w_ms_xret;
  logic [1:0]      w_xret_priv_next;

  function automatic logic [XLEN-1:0] f_warl_mstatus(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] m;
    m = v & L_MSTATUS_W;
    if (m[MS_MPP +: 2] == 2'b10) m[MS_MPP +: 2] = PRIV_M;
    else if (!HAS_S && (m[MS_MPP +: 2] == PRIV_S)) m[MS_MPP +: 2] = PRIV_U;
    return m;
  endfunction

  function automatic logic [XLEN-1:0] f_warl_tvec(input logic [XLEN-1:0] v);
    return {v[XLEN-1:2], v[1] ? 2'b00 : v[1:0]};
  endfunction

  assign w_mip = r_mip_sw | XLEN'({irq_ext[2], 3'b000, irq_ext[1], 3'b000, irq_ext[0], 3'b000});

  irq_arbiter #(.HAS_S(HAS_S)) u_irq_arbiter (
    .i_mip         (w_mip[11:0]),
    .i_mie         (r_mie[11:0]),
    .i_mideleg     (r_mideleg[11:0]),
    .i_priv        (r_priv),
    .i_mstatus_mie (r_mstatus[MS_MIE]),
    .i_mstatus_sie (r_mstatus[MS_SIE]),
    .o_pending     (w_irq_pend),
    .o_cause       (w_irq_cause)
  );

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    w_rd_raw = '0;
    w_impl   = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:              w_rd_raw = r_mstatus;
      CSR_MISA:                 w_rd_raw = L_MISA;
      CSR_MEDELEG:              w_rd_raw = r_medeleg;
      CSR_MIDELEG:              w_rd_raw = r_mideleg;
      CSR_MIE:                  w_rd_raw = r_mie;
      CSR_MIP:                  w_rd_raw = w_mip;
      CSR_MTVEC:                w_rd_raw = r_mtvec;
      CSR_MSCRATCH:             w_rd_raw = r_mscratch;
      CSR_MEPC:                 w_rd_raw = r_mepc;
      CSR_MCAUSE:               w_rd_raw = r_mcause;
      CSR_MTVAL:                w_rd_raw = r_mtval;
      CSR_MCYCLE, CSR_CYCLE:    w_rd_raw = XLEN'(r_mcycle);
      CSR_MINSTRET, CSR_INSTRET: w_rd_raw = XLEN'(r_minstret);
      CSR_MHARTID:              w_rd_raw = '0;
      CSR_SSTATUS:  begin w_impl = HAS_S; w_rd_raw = r_mstatus & L_SSTATUS; end
      CSR_SIE:      begin w_impl = HAS_S; w_rd_raw = r_mie & L_SIP;         end
      CSR_SIP:      begin w_impl = HAS_S; w_rd_raw = w_mip & L_SIP;         end
      CSR_STVEC:    begin w_impl = HAS_S; w_rd_raw = r_stvec;               end
      CSR_SSCRATCH: begin w_impl = HAS_S; w_rd_raw = r_sscratch;            end
      CSR_SEPC:     begin w_impl = HAS_S; w_rd_raw = r_sepc;                end
      CSR_SCAUSE:   begin w_impl = HAS_S; w_rd_raw = r_scause;              end
      CSR_STVAL:    begin w_impl = HAS_S; w_rd_raw = r_stval;               end
      CSR_SATP:     begin w_impl = HAS_S; w_rd_raw = r_satp;                end
      default:      w_impl = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_op_e'(csr_op))
      OP_RW:   w_wval = csr_wdata;
      OP_RS:   w_wval = w_rd_raw | csr_wdata;
      OP_RC:   w_wval = w_rd_raw & ~csr_wdata;
      default: w_wval = w_rd_raw;
    endcase
  end

  assign w_access      = csr_valid && (csr_op != 2'b00);
  assign w_csr_illegal = w_access && (!w_impl || (csr_addr[9:8] > r_priv)
                                      || (csr_wr_en && (csr_addr[11:10] == 2'b11)));
  assign w_xret_bad    = xret_valid && ((xret_priv > r_priv)
                                        || !((xret_priv == PRIV_M) || (HAS_S && (xret_priv == PRIV_S))));
  assign w_take_irq    = irq_take && w_irq_pend;
  assign w_trap        = exc_valid || w_csr_illegal || w_xret_bad || w_take_irq;
  assign w_xret_ok     = xret_valid && !w_trap;
  assign w_csr_we      = w_access && csr_wr_en && !w_trap;

  // Trap source selection follows exception > illegal > interrupt.
  always_comb begin
    w_t_irq   = 1'b0;
    w_t_cause = exc_cause;
    w_t_epc   = exc_pc;
    w_t_tval  = exc_tval;
    if (!exc_valid) begin
      if (w_csr_illegal) begin
        w_t_cause = CAUSE_ILLEGAL_INSN;
        w_t_tval  = XLEN'(csr_insn);
      end else if (w_xret_bad) begin
        w_t_cause = CAUSE_ILLEGAL_INSN;
        w_t_tval  = '0;
      end else begin
        w_t_irq   = 1'b1;
        w_t_cause = w_irq_cause;
        w_t_epc   = irq_pc;
        w_t_tval  = '0;
      end
    end
  end

  assign w_deleg_vec = w_t_irq ? r_mideleg : r_medeleg;
  assign w_to_s      = HAS_S && (r_priv != PRIV_M) && |(w_deleg_vec & (XLEN'(1) << w_t_cause));
  assign w_tvec      = w_to_s ? r_stvec : r_mtvec;
  assign w_vectored  = (w_tvec[1:0] == 2'b01) && w_t_irq && (32'(w_t_cause) <= VEC_MAX);
  assign w_handler   = {w_tvec[XLEN-1:2], 2'b00} + (w_vectored ? (XLEN'(w_t_cause) << 2) : '0);

  always_comb begin
    w_ms_trap = r_mstatus;
    w_ms_xret = r_mstatus;
    if (w_to_s) begin
      w_ms_trap[MS_SPIE] = r_mstatus[MS_SIE];
      w_ms_trap[MS_SIE]  = 1'b0;
      w_ms_trap[MS_SPP]  = (r_priv == PRIV_S);
    end else begin
      w_ms_trap[MS_MPIE]     = r_mstatus[MS_MIE];
      w_ms_trap[MS_MIE]      = 1'b0;
      w_ms_trap[MS_MPP +: 2] = r_priv;
    end
    if (xret_priv == PRIV_M) begin
      w_ms_xret[MS_MIE]      = r_mstatus[MS_MPIE];
      w_ms_xret[MS_MPIE]     = 1'b1;
      w_ms_xret[MS_MPP +: 2] = PRIV_M;
      w_xret_priv_next       = r_mstatus[MS_MPP +: 2];
    end else begin
      w_ms_xret[MS_SIE]  = r_mstatus[MS_SPIE];
      w_ms_xret[MS_SPIE] = 1'b1;
      w_ms_xret[MS_SPP]  = 1'b0;
      w_xret_priv_next   = r_mstatus[MS_SPP] ? PRIV_S : PRIV_U;
    end
  end

  assign csr_rdata   = (w_impl && !w_csr_illegal) ? w_rd_raw : '0;
  assign redirect    = !reset && (w_trap || w_xret_ok);
  assign redirect_pc = w_trap ? w_handler : ((xret_priv == PRIV_M) ? r_mepc : r_sepc);
  assign irq_pending = !reset && w_irq_pend;
  assign priv_mode   = r_priv;
  assign satp        = r_satp;
  assign satp_write  = !reset && HAS_S && w_csr_we && (csr_addr == CSR_SATP);

  // NOTE: each CSR is its own flop with an explicit reset value; non-blocking
  // assignments throughout, and the CSR write sits after the counter increments
  // so a same-cycle write to a counter wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_priv     <= PRIV_M;
      r_mstatus  <= '0; r_medeleg <= '0; r_mideleg <= '0; r_mie  <= '0; r_mip_sw <= '0;
      r_mtvec    <= '0; r_mscratch <= '0; r_mepc  <= '0; r_mcause <= '0; r_mtval <= '0;
      r_stvec    <= '0; r_sscratch <= '0; r_sepc  <= '0; r_scause <= '0; r_stval <= '0;
      r_satp     <= '0; r_mcycle   <= '0; r_minstret <= '0;
    end else begin
      r_mcycle <= r_mcycle + 1'b1;
      if (retire) r_minstret <= r_minstret + 1'b1;
      if (w_trap) begin
        r_mstatus <= w_ms_trap;
        if (w_to_s) begin
          r_sepc   <= {w_t_epc[XLEN-1:1], 1'b0};
          r_scause <= {w_t_irq, {(XLEN-7){1'b0}}, w_t_cause};
          r_stval  <= w_t_tval;
          r_priv   <= PRIV_S;
        end else begin
          r_mepc   <= {w_t_epc[XLEN-1:1], 1'b0};
          r_mcause <= {w_t_irq, {(XLEN-7){1'b0}}, w_t_cause};
          r_mtval  <= w_t_tval;
          r_priv   <= PRIV_M;
        end
      end else if (w_xret_ok) begin
        r_mstatus <= w_ms_xret;
        r_priv    <= w_xret_priv_next;
      end else if (w_csr_we) begin
        case (csr_addr)
          CSR_MSTATUS:  r_mstatus  <= f_warl_mstatus(w_wval);
          CSR_MEDELEG:  if (HAS_S) r_medeleg <= w_wval;
          CSR_MIDELEG:  if (HAS_S) r_mideleg <= w_wval & L_SIP;
          CSR_MIE:      r_mie      <= w_wval & L_MIE_W;
          CSR_MIP:      r_mip_sw   <= w_wval & L_MIP_SW_W;
          CSR_MTVEC:    r_mtvec    <= f_warl_tvec(w_wval);
          CSR_MSCRATCH: r_mscratch <= w_wval;
          CSR_MEPC:     r_mepc     <= {w_wval[XLEN-1:1], 1'b0};
          CSR_MCAUSE:   r_mcause   <= w_wval;
          CSR_MTVAL:    r_mtval    <= w_wval;
          CSR_MCYCLE:   r_mcycle   <= w_wval[CNT_W-1:0];
          CSR_MINSTRET: r_minstret <= w_wval[CNT_W-1:0];
          CSR_SSTATUS:  r_mstatus  <= f_warl_mstatus((r_mstatus & ~L_SSTATUS) | (w_wval & L_SSTATUS));
          CSR_SIE:      r_mie      <= (r_mie & ~L_SIP) | (w_wval & L_SIP);
          CSR_SIP:      r_mip_sw   <= w_wval & L_SIP;
          CSR_STVEC:    r_stvec    <= f_warl_tvec(w_wval);
          CSR_SSCRATCH: r_sscratch <= w_wval;
          CSR_SEPC:     r_sepc     <= {w_wval[XLEN-1:1], 1'b0};
          CSR_SCAUSE:   r_scause   <= w_wval;
          CSR_STVAL:    r_stval    <= w_wval;
          CSR_SATP:     r_satp     <= w_wval;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: reset, access checks, interrupt vectoring,
// delegation, counters and event precedence, with hand-computed expectations.
module tb_csr_trap_unit;

  logic        clk;
  logic        reset;
  logic        csr_valid;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [63:0] csr_wdata;
  logic        csr_wr_en;
  logic [31:0] csr_insn;
  logic [63:0] csr_rdata;
  logic        retire;
  logic        exc_valid;
  logic [5:0]  exc_cause;
  logic [63:0] exc_pc;
  logic [63:0] exc_tval;
  logic [2:0]  irq_ext;
  logic        irq_take;
  logic [63:0] irq_pc;
  logic        xret_valid;
  logic [1:0]  xret_priv;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        irq_pending;
  logic [1:0]  priv_mode;
  logic [63:0] satp;
  logic        satp_write;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] rd;

  csr_trap_unit #(.XLEN(64), .CNT_W(64), .HAS_S(1'b1), .VEC_MAX(16)) dut (
    .clk(clk), .reset(reset),
    .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
    .csr_wr_en(csr_wr_en), .csr_insn(csr_insn), .csr_rdata(csr_rdata),
    .retire(retire), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .exc_tval(exc_tval), .irq_ext(irq_ext), .irq_take(irq_take), .irq_pc(irq_pc),
    .xret_valid(xret_valid), .xret_priv(xret_priv),
    .redirect(redirect), .redirect_pc(redirect_pc), .irq_pending(irq_pending),
    .priv_mode(priv_mode), .satp(satp), .satp_write(satp_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle();
    csr_valid = 1'b0; csr_addr = '0; csr_op = 2'b00; csr_wdata = '0;
    csr_wr_en = 1'b0; csr_insn = '0; retire = 1'b0;
    exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
    irq_take = 1'b0; irq_pc = '0; xret_valid = 1'b0; xret_priv = 2'b00;
  endtask

  // Combinational peek: no clock edge passes while the read is presented.
  task automatic csr_rd(input logic [11:0] addr, output logic [63:0] data);
    csr_valid = 1'b1; csr_addr = addr; csr_op = 2'b10; csr_wdata = '0; csr_wr_en = 1'b0;
    #1;
    data = csr_rdata;
    idle();
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [1:0] op, input logic [63:0] data);
    csr_valid = 1'b1; csr_addr = addr; csr_op = op; csr_wdata = data; csr_wr_en = 1'b1;
    @(negedge clk);
    idle();
  endtask

  task automatic do_mret(input logic [63:0] exp_pc);
    xret_valid = 1'b1; xret_priv = 2'b11;
    #1;
    check("mret_redirect", {63'd0, redirect}, 64'd1);
    check("mret_pc", redirect_pc, exp_pc);
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    irq_ext = 3'b000;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_redirect", {63'd0, redirect}, 64'd0);
    check("rst_irq_pending", {63'd0, irq_pending}, 64'd0);
    check("rst_satp_write", {63'd0, satp_write}, 64'd0);
    check("rst_priv", {62'd0, priv_mode}, 64'd3);
    reset = 1'b0;
    @(negedge clk);

    // misa value and write-ignore
    csr_rd(12'h301, rd);
    check("misa", rd, 64'h8000_0000_0014_1101);
    csr_valid = 1'b1; csr_addr = 12'h301; csr_op = 2'b01; csr_wdata = '0; csr_wr_en = 1'b1;
    #1;
    check("misa_wr_no_trap", {63'd0, redirect}, 64'd0);
    @(negedge clk);
    idle();
    csr_rd(12'h301, rd);
    check("misa_after_wr", rd, 64'h8000_0000_0014_1101);

    // Enter S via mret, then touch an M CSR from S
    csr_wr(12'h300, 2'b01, 64'h800);
    csr_wr(12'h341, 2'b01, 64'h1000);
    do_mret(64'h1000);
    check("priv_s", {62'd0, priv_mode}, 64'd1);
    csr_valid = 1'b1; csr_addr = 12'h340; csr_op = 2'b01; csr_wdata = 64'h1234;
    csr_wr_en = 1'b1; csr_insn = 32'h3400_9073;
    #1;
    check("ill_redirect", {63'd0, redirect}, 64'd1);
    check("ill_rdata", csr_rdata, 64'd0);
    check("ill_pc", redirect_pc, 64'd0);
    @(negedge clk);
    idle();
    check("ill_priv", {62'd0, priv_mode}, 64'd3);
    csr_rd(12'h342, rd); check("ill_mcause", rd, 64'd2);
    csr_rd(12'h343, rd); check("ill_mtval", rd, 64'h3400_9073);
    csr_rd(12'h340, rd); check("ill_mscratch", rd, 64'd0);

    // Vectored machine timer interrupt
    csr_wr(12'h305, 2'b01, 64'h8000_0001);
    csr_wr(12'h304, 2'b01, 64'h80);
    csr_wr(12'h300, 2'b10, 64'h8);
    irq_ext = 3'b010;
    #1;
    check("irq_pending", {63'd0, irq_pending}, 64'd1);
    csr_rd(12'h344, rd); check("mip_mtip", rd, 64'h80);
    irq_take = 1'b1; irq_pc = 64'h2000;
    #1;
    check("irq_redirect", {63'd0, redirect}, 64'd1);
    check("irq_vec_pc", redirect_pc, 64'h8000_001C);
    @(negedge clk);
    idle();
    csr_rd(12'h342, rd); check("irq_mcause", rd, 64'h8000_0000_0000_0007);
    csr_rd(12'h341, rd); check("irq_mepc", rd, 64'h2000);
    csr_rd(12'h300, rd); check("irq_mstatus", rd, 64'h1880);
    #1;
    check("irq_masked_in_m", {63'd0, irq_pending}, 64'd0);
    irq_ext = 3'b000;

    // Delegated exception from S, then non-delegated, then from M
    csr_wr(12'h302, 2'b01, 64'h100);
    csr_wr(12'h105, 2'b01, 64'h9000_0003);
    csr_wr(12'h300, 2'b01, 64'h800);
    csr_wr(12'h341, 2'b01, 64'h3001);
    do_mret(64'h3000);
    exc_valid = 1'b1; exc_cause = 6'd8; exc_pc = 64'h4000; exc_tval = 64'h55;
    #1;
    check("deleg_pc", redirect_pc, 64'h9000_0000);
    @(negedge clk);
    idle();
    check("deleg_priv", {62'd0, priv_mode}, 64'd1);
    csr_rd(12'h141, rd); check("deleg_sepc", rd, 64'h4000);
    csr_rd(12'h142, rd); check("deleg_scause", rd, 64'd8);
    csr_rd(12'h143, rd); check("deleg_stval", rd, 64'h55);
    csr_rd(12'h100, rd); check("deleg_sstatus", rd, 64'h100);
    exc_valid = 1'b1; exc_cause = 6'd9; exc_pc = 64'h4100;
    @(negedge clk);
    idle();
    check("nodeleg_priv", {62'd0, priv_mode}, 64'd3);
    csr_rd(12'h342, rd); check("nodeleg_mcause", rd, 64'd9);
    exc_valid = 1'b1; exc_cause = 6'd8; exc_pc = 64'h4200;
    #1;
    check("m_exc_pc", redirect_pc, 64'h8000_0000);
    @(negedge clk);
    idle();
    check("m_exc_priv", {62'd0, priv_mode}, 64'd3);
    csr_rd(12'h342, rd); check("m_exc_mcause", rd, 64'd8);
    csr_rd(12'h341, rd); check("m_exc_mepc", rd, 64'h4200);
    csr_rd(12'h141, rd); check("m_exc_sepc_kept", rd, 64'h4000);

    // Counter write, wrap, and write-over-increment
    csr_wr(12'hB00, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF);
    csr_rd(12'hB00, rd); check("mcycle_written", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    csr_rd(12'hB00, rd); check("mcycle_wrap", rd, 64'd0);
    retire = 1'b1;
    csr_wr(12'hB02, 2'b01, 64'h10);
    csr_rd(12'hB02, rd); check("minstret_write_wins", rd, 64'h10);
    retire = 1'b1;
    @(negedge clk);
    idle();
    csr_rd(12'hC02, rd); check("instret_shadow", rd, 64'h11);
    csr_valid = 1'b1; csr_addr = 12'hC00; csr_op = 2'b01; csr_wdata = 64'h1; csr_wr_en = 1'b1;
    #1;
    check("ro_write_redirect", {63'd0, redirect}, 64'd1);
    check("ro_write_rdata", csr_rdata, 64'd0);
    idle();

    // satp write strobe
    csr_valid = 1'b1; csr_addr = 12'h180; csr_op = 2'b01;
    csr_wdata = 64'h8000_0000_0000_1234; csr_wr_en = 1'b1;
    #1;
    check("satp_write_pulse", {63'd0, satp_write}, 64'd1);
    @(negedge clk);
    idle();
    #1;
    check("satp_value", satp, 64'h8000_0000_0000_1234);
    check("satp_write_low", {63'd0, satp_write}, 64'd0);

    // Exception beats a same-cycle mret and CSR write
    csr_wr(12'h300, 2'b11, 64'h1800);
    exc_valid = 1'b1; exc_cause = 6'd5; exc_pc = 64'h5000;
    xret_valid = 1'b1; xret_priv = 2'b11;
    csr_valid = 1'b1; csr_addr = 12'h340; csr_op = 2'b01; csr_wdata = 64'hABCD; csr_wr_en = 1'b1;
    #1;
    check("race_redirect", {63'd0, redirect}, 64'd1);
    check("race_pc", redirect_pc, 64'h8000_0000);
    @(negedge clk);
    idle();
    check("race_priv", {62'd0, priv_mode}, 64'd3);
    csr_rd(12'h340, rd); check("race_mscratch", rd, 64'd0);
    csr_rd(12'h342, rd); check("race_mcause", rd, 64'd5);
    csr_rd(12'h341, rd); check("race_mepc", rd, 64'h5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
